// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the multi-cycle ALU control:
// MIPS opcodes/functs, ALU codes, FSM states and instruction classes.
package alu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    localparam logic [3:0] ALU_SLL  = 4'b0000;
    localparam logic [3:0] ALU_SRL  = 4'b0001;
    localparam logic [3:0] ALU_SRA  = 4'b0010;
    localparam logic [3:0] ALU_LUI  = 4'b0011;
    localparam logic [3:0] ALU_SLLV = 4'b0100;
    localparam logic [3:0] ALU_SRLV = 4'b0101;
    localparam logic [3:0] ALU_SRAV = 4'b0110;
    localparam logic [3:0] ALU_ADD  = 4'b1000;
    localparam logic [3:0] ALU_SUB  = 4'b1001;
    localparam logic [3:0] ALU_SLT  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_AND  = 4'b1100;
    localparam logic [3:0] ALU_OR   = 4'b1101;
    localparam logic [3:0] ALU_NOR  = 4'b1110;
    localparam logic [3:0] ALU_XOR  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_MDU
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP,
        CL_MDU,
        CL_ILLEGAL
    } iclass_t;

endpackage

// File: rtl/alu_func_decode.sv
// Combinational {opcode,funct} decoder: ALU code, class and operand
// controls. Shared with the single-cycle core.
module alu_func_decode
    import alu_ctrl_pkg::*;
#(
    parameter int ENABLE_MDU = 1
) (
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_func,
    output iclass_t    o_class,
    output logic       o_src_b_imm,
    output logic       o_imm_zext,
    output logic       o_reg_dst_rt,
    output logic       o_illegal
);

    localparam iclass_t MDU_CLASS =
        (ENABLE_MDU != 0) ? CL_MDU : CL_ILLEGAL;

    always_comb begin
        o_alu_func   = ALU_ADD;
        o_class      = CL_ILLEGAL;
        o_src_b_imm  = 1'b0;
        o_imm_zext   = 1'b0;
        o_reg_dst_rt = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_class = CL_ALU;
                case (i_funct)
                    FN_ADD, FN_ADDU: o_alu_func = ALU_ADD;
                    FN_SUB, FN_SUBU: o_alu_func = ALU_SUB;
                    FN_AND:  o_alu_func = ALU_AND;
                    FN_OR:   o_alu_func = ALU_OR;
                    FN_XOR:  o_alu_func = ALU_XOR;
                    FN_NOR:  o_alu_func = ALU_NOR;
                    FN_SLT:  o_alu_func = ALU_SLT;
                    FN_SLTU: o_alu_func = ALU_SLTU;
                    FN_SLL:  o_alu_func = ALU_SLL;
                    FN_SRL:  o_alu_func = ALU_SRL;
                    FN_SRA:  o_alu_func = ALU_SRA;
                    FN_SLLV: o_alu_func = ALU_SLLV;
                    FN_SRLV: o_alu_func = ALU_SRLV;
                    FN_SRAV: o_alu_func = ALU_SRAV;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:
                        o_class = MDU_CLASS;
                    default: o_class = CL_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                o_class      = CL_ALU;
                o_src_b_imm  = 1'b1;
                o_reg_dst_rt = 1'b1;
                case (i_opcode)
                    OP_SLTI:  o_alu_func = ALU_SLT;
                    OP_SLTIU: o_alu_func = ALU_SLTU;
                    OP_ANDI:  o_alu_func = ALU_AND;
                    OP_ORI:   o_alu_func = ALU_OR;
                    OP_XORI:  o_alu_func = ALU_XOR;
                    OP_LUI:   o_alu_func = ALU_LUI;
                    default:  o_alu_func = ALU_ADD;
                endcase
                // logical immediates are unsigned in MIPS
                o_imm_zext = (i_opcode == OP_ANDI) ||
                             (i_opcode == OP_ORI)  ||
                             (i_opcode == OP_XORI);
            end
            OP_LW: begin
                o_class      = CL_LOAD;
                o_src_b_imm  = 1'b1;
                o_reg_dst_rt = 1'b1;
            end
            OP_SW: begin
                o_class     = CL_STORE;
                o_src_b_imm = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                o_class    = CL_BRANCH;
                o_alu_func = ALU_SUB;
            end
            OP_J: o_class = CL_JUMP;
            default: o_class = CL_ILLEGAL;
        endcase
    end

    assign o_illegal = (o_class == CL_ILLEGAL);

endmodule

// File: rtl/alu_ctrl_mc.sv
// Multi-cycle ALU/datapath control: DECODE/EXEC/MEM/WB sequencing
// with an iterative multiply/divide wait state.
module alu_ctrl_mc
    import alu_ctrl_pkg::*;
#(
    parameter int ENABLE_MDU = 1,
    parameter int MDU_CYCLES = 32,
    parameter int CNT_W      = $clog2(MDU_CYCLES + 1)
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    input  logic       i_alu_zero,
    input  logic       i_mem_ack,
    output logic       o_ready,
    output logic [3:0] o_alu_func,
    output logic       o_src_b_imm,
    output logic       o_imm_zext,
    output logic       o_reg_dst_rt,
    output logic       o_reg_we,
    output logic       o_mem_re,
    output logic       o_mem_we,
    output logic       o_branch,
    output logic       o_mdu_start,
    output logic       o_mdu_busy,
    output logic       o_done,
    output logic       o_illegal
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_opcode;
    logic [5:0]       r_funct;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0] w_alu_func;
    iclass_t    w_class;
    logic       w_src_b_imm;
    logic       w_imm_zext;
    logic       w_reg_dst_rt;
    logic       w_illegal;

    alu_func_decode #(
        .ENABLE_MDU (ENABLE_MDU)
    ) u_dec (
        .i_opcode     (r_opcode),
        .i_funct      (r_funct),
        .o_alu_func   (w_alu_func),
        .o_class      (w_class),
        .o_src_b_imm  (w_src_b_imm),
        .o_imm_zext   (w_imm_zext),
        .o_reg_dst_rt (w_reg_dst_rt),
        .o_illegal    (w_illegal)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_opcode <= '0;
            r_funct  <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && i_valid) begin
                r_opcode <= i_opcode;
                r_funct  <= i_funct;
            end
            if (r_state == ST_DECODE && w_next == ST_MDU) begin
                r_cnt <= CNT_LOAD;
            end else if (r_state == ST_MDU && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        o_ready      = 1'b0;
        o_alu_func   = ALU_ADD;
        o_src_b_imm  = 1'b0;
        o_imm_zext   = 1'b0;
        o_reg_dst_rt = 1'b0;
        o_reg_we     = 1'b0;
        o_mem_re     = 1'b0;
        o_mem_we     = 1'b0;
        o_branch     = 1'b0;
        o_mdu_start  = 1'b0;
        o_mdu_busy   = 1'b0;
        o_done       = 1'b0;
        o_illegal    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) w_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_illegal) begin
                    o_illegal = 1'b1;
                    w_next    = ST_IDLE;
                end else if (w_class == CL_MDU) begin
                    w_next = ST_MDU;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                o_alu_func   = w_alu_func;
                o_src_b_imm  = w_src_b_imm;
                o_imm_zext   = w_imm_zext;
                o_reg_dst_rt = w_reg_dst_rt;
                case (w_class)
                    CL_LOAD, CL_STORE: w_next = ST_MEM;
                    CL_BRANCH: begin
                        o_branch = (r_opcode == OP_BNE) ?
                                   !i_alu_zero : i_alu_zero;
                        o_done   = 1'b1;
                        w_next   = ST_IDLE;
                    end
                    CL_JUMP: begin
                        o_branch = 1'b1;
                        o_done   = 1'b1;
                        w_next   = ST_IDLE;
                    end
                    default: w_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                o_src_b_imm = 1'b1;
                o_mem_re    = (w_class == CL_LOAD);
                o_mem_we    = (w_class != CL_LOAD);
                if (i_mem_ack) begin
                    if (w_class == CL_LOAD) begin
                        w_next = ST_WB;
                    end else begin
                        o_done = 1'b1;
                        w_next = ST_IDLE;
                    end
                end
            end
            ST_WB: begin
                o_alu_func   = w_alu_func;
                o_src_b_imm  = w_src_b_imm;
                o_imm_zext   = w_imm_zext;
                o_reg_dst_rt = w_reg_dst_rt;
                o_reg_we     = 1'b1;
                o_done       = 1'b1;
                w_next       = ST_IDLE;
            end
            ST_MDU: begin
                o_mdu_busy  = 1'b1;
                // counter sits at its load value only on the entry cycle
                o_mdu_start = (r_cnt == CNT_LOAD);
                if (r_cnt == '0) begin
                    o_done = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Self-checking bench for alu_ctrl_mc: three configurations share
// one instruction stream; retirements are checked against a scoreboard.
module tb_alu_ctrl_mc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       alu_zero = 1'b0;
    logic       mem_ack = 1'b0;

    logic       ready[3];
    logic [3:0] alu_func[3];
    logic       src_b_imm[3];
    logic       imm_zext[3];
    logic       reg_dst_rt[3];
    logic       reg_we[3];
    logic       mem_re[3];
    logic       mem_we[3];
    logic       branch[3];
    logic       mdu_start[3];
    logic       mdu_busy[3];
    logic       done[3];
    logic       illegal[3];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        bit         ill;
        bit         we;
        logic [3:0] func;
    } exp_t;

    exp_t sb[3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_ctrl_mc #(.ENABLE_MDU(1), .MDU_CYCLES(4)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid),
        .i_opcode(opcode), .i_funct(funct),
        .i_alu_zero(alu_zero), .i_mem_ack(mem_ack),
        .o_ready(ready[0]), .o_alu_func(alu_func[0]),
        .o_src_b_imm(src_b_imm[0]), .o_imm_zext(imm_zext[0]),
        .o_reg_dst_rt(reg_dst_rt[0]), .o_reg_we(reg_we[0]),
        .o_mem_re(mem_re[0]), .o_mem_we(mem_we[0]),
        .o_branch(branch[0]), .o_mdu_start(mdu_start[0]),
        .o_mdu_busy(mdu_busy[0]), .o_done(done[0]),
        .o_illegal(illegal[0])
    );

    alu_ctrl_mc #(.ENABLE_MDU(1), .MDU_CYCLES(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid),
        .i_opcode(opcode), .i_funct(funct),
        .i_alu_zero(alu_zero), .i_mem_ack(mem_ack),
        .o_ready(ready[1]), .o_alu_func(alu_func[1]),
        .o_src_b_imm(src_b_imm[1]), .o_imm_zext(imm_zext[1]),
        .o_reg_dst_rt(reg_dst_rt[1]), .o_reg_we(reg_we[1]),
        .o_mem_re(mem_re[1]), .o_mem_we(mem_we[1]),
        .o_branch(branch[1]), .o_mdu_start(mdu_start[1]),
        .o_mdu_busy(mdu_busy[1]), .o_done(done[1]),
        .o_illegal(illegal[1])
    );

    alu_ctrl_mc #(.ENABLE_MDU(0), .MDU_CYCLES(32)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid),
        .i_opcode(opcode), .i_funct(funct),
        .i_alu_zero(alu_zero), .i_mem_ack(mem_ack),
        .o_ready(ready[2]), .o_alu_func(alu_func[2]),
        .o_src_b_imm(src_b_imm[2]), .o_imm_zext(imm_zext[2]),
        .o_reg_dst_rt(reg_dst_rt[2]), .o_reg_we(reg_we[2]),
        .o_mem_re(mem_re[2]), .o_mem_we(mem_we[2]),
        .o_branch(branch[2]), .o_mdu_start(mdu_start[2]),
        .o_mdu_busy(mdu_busy[2]), .o_done(done[2]),
        .o_illegal(illegal[2])
    );

    task automatic push(input int i, input int c, input bit ill,
                        input bit we, input logic [3:0] f);
        exp_t e;
        e.cyc  = c;
        e.ill  = ill;
        e.we   = we;
        e.func = f;
        sb[i].push_back(e);
    endtask

    task automatic push_all(input int c, input bit we,
                            input logic [3:0] f);
        for (int i = 0; i < 3; i++) push(i, c, 1'b0, we, f);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (done[i] || illegal[i]) begin
                n_cmp++;
                if (sb[i].size() == 0) begin
                    n_bad++;
                    $display("FAIL retire%0d: unexpected done=%b ill=%b at cycle %0d, required none",
                             i, done[i], illegal[i], cyc);
                end else begin
                    e = sb[i].pop_front();
                    if (cyc !== e.cyc || illegal[i] !== e.ill ||
                        done[i] !== !e.ill || reg_we[i] !== e.we ||
                        alu_func[i] !== e.func) begin
                        n_bad++;
                        $display("FAIL retire%0d: got cyc=%0d ill=%b we=%b func=%b, required cyc=%0d ill=%b we=%b func=%b",
                                 i, cyc, illegal[i], reg_we[i], alu_func[i],
                                 e.cyc, e.ill, e.we, e.func);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        logic [10:0] v;
        rst_n = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            v = {src_b_imm[i], imm_zext[i], reg_dst_rt[i], reg_we[i],
                 mem_re[i], mem_we[i], branch[i], mdu_start[i],
                 mdu_busy[i], done[i], illegal[i]};
            n_cmp++;
            if (ready[i] !== 1'b1 || alu_func[i] !== 4'b1000 ||
                v !== 11'b0) begin
                n_bad++;
                $display("FAIL reset%0d: got ready=%b func=%b other=%b, required 1 1000 0",
                         i, ready[i], alu_func[i], v);
            end
        end
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] f;
        logic       imm;
        logic       zx;
        logic       rt;
    } alu_vec_t;

    function automatic alu_vec_t mk(input logic [5:0] op,
                                    input logic [5:0] fn,
                                    input logic [3:0] f,
                                    input logic imm, input logic zx,
                                    input logic rt);
        alu_vec_t v;
        v.op = op; v.fn = fn; v.f = f;
        v.imm = imm; v.zx = zx; v.rt = rt;
        return v;
    endfunction

    task automatic test_alu_ops();
        alu_vec_t tbl[$];
        int acc;
        logic [5:0] rf;
        tbl.push_back(mk(6'o00, 6'b100000, 4'b1000, 0, 0, 0));
        tbl.push_back(mk(6'o00, 6'b100010, 4'b1001, 0, 0, 0));
        tbl.push_back(mk(6'o00, 6'b100100, 4'b1100, 0, 0, 0));
        tbl.push_back(mk(6'o00, 6'b100101, 4'b1101, 0, 0, 0));
        tbl.push_back(mk(6'o00, 6'b100110, 4'b1111, 0, 0, 0));
        tbl.push_back(mk(6'o00, 6'b100111, 4'b1110, 0, 0, 0));
        tbl.push_back(mk(6'o00, 6'b101010, 4'b1010, 0, 0, 0));
        tbl.push_back(mk(6'o00, 6'b101011, 4'b1011, 0, 0, 0));
        tbl.push_back(mk(6'o00, 6'b000000, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(6'o00, 6'b000010, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(6'o00, 6'b000011, 4'b0010, 0, 0, 0));
        tbl.push_back(mk(6'o00, 6'b000100, 4'b0100, 0, 0, 0));
        tbl.push_back(mk(6'o00, 6'b000110, 4'b0101, 0, 0, 0));
        tbl.push_back(mk(6'o00, 6'b000111, 4'b0110, 0, 0, 0));
        tbl.push_back(mk(6'b001000, 6'o00, 4'b1000, 1, 0, 1));
        tbl.push_back(mk(6'b001101, 6'o00, 4'b1101, 1, 1, 1));
        tbl.push_back(mk(6'b001100, 6'o00, 4'b1100, 1, 1, 1));
        tbl.push_back(mk(6'b001110, 6'o00, 4'b1111, 1, 1, 1));
        tbl.push_back(mk(6'b001010, 6'o00, 4'b1010, 1, 0, 1));
        tbl.push_back(mk(6'b001011, 6'o00, 4'b1011, 1, 0, 1));
        tbl.push_back(mk(6'b001111, 6'o00, 4'b0011, 1, 0, 1));
        foreach (tbl[t]) begin
            rf = (tbl[t].op == 6'o00) ? tbl[t].fn :
                 6'($urandom_range(0, 63));
            opcode = tbl[t].op;
            funct  = rf;
            valid  = 1'b1;
            acc = cyc;
            push_all(acc + 3, 1'b1, tbl[t].f);
            tick();
            valid = 1'b0;
            n_cmp++;
            if (ready[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL alu%0d_busy: got ready=%b required 0", t, ready[0]);
            end
            tick();
            n_cmp++;
            if (alu_func[0] !== tbl[t].f || src_b_imm[0] !== tbl[t].imm ||
                imm_zext[0] !== tbl[t].zx || reg_dst_rt[0] !== tbl[t].rt ||
                reg_we[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL alu%0d_exec: got func=%b imm=%b zx=%b rt=%b we=%b, required %b %b %b %b 0",
                         t, alu_func[0], src_b_imm[0], imm_zext[0],
                         reg_dst_rt[0], reg_we[0], tbl[t].f, tbl[t].imm,
                         tbl[t].zx, tbl[t].rt);
            end
            tick();
            n_cmp++;
            if (reg_we[0] !== 1'b1 || ready[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL alu%0d_wb: got we=%b ready=%b, required 1 0",
                         t, reg_we[0], ready[0]);
            end
            tick();
            n_cmp++;
            if (ready[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL alu%0d_ready: got %b required 1", t, ready[0]);
            end
        end
    endtask

    task automatic test_mem();
        int acc;
        int n_re;
        int n_we;
        int n_rwe;
        int we_cyc;
        opcode = 6'b100011;
        funct  = 6'b0;
        valid  = 1'b1;
        acc = cyc;
        push_all(acc + 7, 1'b1, 4'b1000);
        n_re = 0; n_rwe = 0; we_cyc = -1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            valid = 1'b0;
            if (mem_re[0]) n_re++;
            if (reg_we[0]) begin
                n_rwe++;
                we_cyc = k;
            end
            mem_ack = (k == 1) || (k == 6);
        end
        mem_ack = 1'b0;
        n_cmp++;
        if (n_re !== 4 || n_rwe !== 1 || we_cyc !== 7) begin
            n_bad++;
            $display("FAIL lw_stall: got re_cycles=%0d we_cycles=%0d we_at=%0d, required 4 1 7",
                     n_re, n_rwe, we_cyc);
        end
        n_cmp++;
        if (ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL lw_ready: got %b required 1", ready[0]);
        end
        opcode = 6'b101011;
        valid  = 1'b1;
        acc = cyc;
        push_all(acc + 3, 1'b0, 4'b1000);
        n_we = 0; n_rwe = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            valid = 1'b0;
            if (mem_we[0]) n_we++;
            if (reg_we[0]) n_rwe++;
            mem_ack = (k == 3);
        end
        mem_ack = 1'b0;
        n_cmp++;
        if (n_we !== 1 || n_rwe !== 0 || ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL sw: got we_cycles=%0d regwe_cycles=%0d ready=%b, required 1 0 1",
                     n_we, n_rwe, ready[0]);
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops[5] = '{6'b000100, 6'b000100, 6'b000101,
                               6'b000101, 6'b000010};
        logic zs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic exb[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] exf[5] = '{4'b1001, 4'b1001, 4'b1001,
                               4'b1001, 4'b1000};
        int acc;
        for (int t = 0; t < 5; t++) begin
            opcode = ops[t];
            funct  = 6'($urandom_range(0, 63));
            valid  = 1'b1;
            acc = cyc;
            push_all(acc + 2, 1'b0, exf[t]);
            tick();
            valid    = 1'b0;
            alu_zero = zs[t];
            tick();
            n_cmp++;
            if (branch[0] !== exb[t] || alu_func[0] !== exf[t]) begin
                n_bad++;
                $display("FAIL branch%0d: got br=%b func=%b, required %b %b",
                         t, branch[0], alu_func[0], exb[t], exf[t]);
            end
            tick();
            alu_zero = 1'b0;
            n_cmp++;
            if (ready[0] !== 1'b1 || branch[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL branch%0d_after: got ready=%b br=%b, required 1 0",
                         t, ready[0], branch[0]);
            end
        end
    endtask

    task automatic test_mdu();
        logic [5:0] fns[2] = '{6'b011000, 6'b011011};
        int acc;
        bit eb0;
        bit es0;
        bit e1;
        for (int t = 0; t < 2; t++) begin
            opcode = 6'b000000;
            funct  = fns[t];
            valid  = 1'b1;
            acc = cyc;
            push(0, acc + 5, 1'b0, 1'b0, 4'b1000);
            push(1, acc + 2, 1'b0, 1'b0, 4'b1000);
            push(2, acc + 1, 1'b1, 1'b0, 4'b1000);
            for (int k = 1; k <= 6; k++) begin
                tick();
                valid = 1'b0;
                eb0 = (k >= 2) && (k <= 5);
                es0 = (k == 2);
                e1  = (k == 2);
                n_cmp++;
                if (mdu_busy[0] !== eb0 || mdu_start[0] !== es0 ||
                    mdu_busy[1] !== e1 || mdu_start[1] !== e1 ||
                    mdu_busy[2] !== 1'b0 || reg_we[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL mdu%0d_c%0d: got busy=%b%b%b start=%b%b, required %b%b0 %b%b",
                             t, k, mdu_busy[0], mdu_busy[1], mdu_busy[2],
                             mdu_start[0], mdu_start[1], eb0, e1, es0, e1);
                end
            end
            n_cmp++;
            if (ready[0] !== 1'b1) begin
                n_bad++;
                $display("FAIL mdu%0d_ready: got %b required 1", t, ready[0]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops[2] = '{6'b111111, 6'b000000};
        logic [5:0] fns[2] = '{6'b100000, 6'b000001};
        int acc;
        for (int t = 0; t < 2; t++) begin
            opcode = ops[t];
            funct  = fns[t];
            valid  = 1'b1;
            acc = cyc;
            for (int i = 0; i < 3; i++) push(i, acc + 1, 1'b1, 1'b0, 4'b1000);
            tick();
            valid = 1'b0;
            n_cmp++;
            if (illegal[0] !== 1'b1 || done[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal%0d: got ill=%b done=%b, required 1 0",
                         t, illegal[0], done[0]);
            end
            tick();
            n_cmp++;
            if (ready[0] !== 1'b1 || illegal[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL illegal%0d_after: got ready=%b ill=%b, required 1 0",
                         t, ready[0], illegal[0]);
            end
        end
    endtask

    task automatic test_valid_held();
        int acc;
        opcode = 6'b000000;
        funct  = 6'b100000;
        valid  = 1'b1;
        acc = cyc;
        push_all(acc + 3, 1'b1, 4'b1000);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 2) begin
                n_cmp++;
                if (alu_func[0] !== 4'b1000) begin
                    n_bad++;
                    $display("FAIL held_exec: got func=%b required 1000", alu_func[0]);
                end
            end
            if (k < 4) begin
                opcode = 6'b111111;
                funct  = 6'b000001;
            end else begin
                valid  = 1'b0;
                opcode = 6'b000000;
                funct  = 6'b000000;
            end
        end
        n_cmp++;
        if (ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL held_ready: got %b required 1", ready[0]);
        end
    endtask

    task automatic test_reset_mid();
        opcode = 6'b100011;
        funct  = 6'b0;
        valid  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            valid = 1'b0;
        end
        n_cmp++;
        if (mem_re[0] !== 1'b1 || ready[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_pre: got re=%b ready=%b, required 1 0",
                     mem_re[0], ready[0]);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_re[0] !== 1'b0 || ready[0] !== 1'b1 ||
            alu_func[0] !== 4'b1000 || src_b_imm[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid: got re=%b ready=%b func=%b imm=%b, required 0 1 1000 0",
                     mem_re[0], ready[0], alu_func[0], src_b_imm[0]);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_mem();
        test_branch();
        test_mdu();
        test_illegal();
        test_valid_held();
        test_reset_mid();
        test_alu_ops();
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (sb[i].size() !== 0) begin
                n_bad++;
                $display("FAIL sb%0d_drain: got %0d pending, required 0",
                         i, sb[i].size());
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_mc.md
Name: alu_ctrl_mc

Overview:
Multi-cycle successor to the single-cycle ALU control. It accepts one MIPS instruction (opcode/funct) per handshake and sequences it through DECODE/EXEC/MEM/WB, driving the ALU function code and datapath strobes on each cycle. It adds SLT/SLTU, variable shifts, LUI, an illegal-instruction flag and an iterative multiply/divide wait, none of which the single-cycle control has. It sits between the instruction register and the multi-cycle datapath.

Parameters:
ENABLE_MDU, 1, 1 = MULT/MULTU/DIV/DIVU supported; 0 = those functs decode as illegal.
MDU_CYCLES, 32, cycles the MDU state is held per mult/div op; legal range is 1 or more.
CNT_W, $clog2(MDU_CYCLES+1), width of the MDU down-counter.

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  asynchronous, active-low reset.
i_valid  in  1  instruction present.
i_opcode  in  6  instruction [31:26].
i_funct  in  6  instruction [5:0].
i_alu_zero  in  1  ALU zero flag, sampled in EXEC.
i_mem_ack  in  1  memory access complete.
o_ready  out  1  block can accept an instruction.
o_alu_func  out  4  ALU function code.
o_src_b_imm  out  1  1 = ALU B operand is the immediate; 0 = rt.
o_imm_zext  out  1  1 = zero-extend immediate (ANDI/ORI/XORI); 0 = sign-extend.
o_reg_dst_rt  out  1  1 = write rt; 0 = write rd.
o_reg_we  out  1  register file write strobe.
o_mem_re  out  1  load request.
o_mem_we  out  1  store request.
o_branch  out  1  load PC with branch/jump target.
o_mdu_start  out  1  one-cycle MDU start pulse.
o_mdu_busy  out  1  MDU operation in progress.
o_done  out  1  one-cycle retire pulse.
o_illegal  out  1  one-cycle illegal-instruction pulse.

Behaviour:
- Clock and reset: one clock, i_clk. i_rst_n is asynchronous and active-low.
- Reset, including mid-operation: state goes to IDLE; captured opcode, captured funct and counter clear to 0; every output is 0 except o_ready=1 and o_alu_func=4'b1000.
- ALU codes:
  - ADD 1000, SUB 1001, AND 1100, OR 1101, NOR 1110, XOR 1111.
  - SLT 1010, SLTU 1011.
  - SLL 0000, SRL 0001, SRA 0010.
  - SLLV 0100, SRLV 0101, SRAV 0110, LUI 0011.
  - No X ever leaves the block; the idle and default code is ADD.
- Outputs are functions of state and the captured registers only, except o_branch, which also depends combinationally on i_alu_zero in EXEC. There is no path from i_opcode/i_funct to any output.
- IDLE:
  - o_ready=1.
  - On i_valid=1, capture opcode and funct, then go to DECODE.
- DECODE (1 cycle), o_ready=0:
  - Unknown opcode/funct: o_illegal=1, next state IDLE, no o_done.
  - MDU funct with ENABLE_MDU=1: next state MDU.
  - Otherwise: next state EXEC.
- EXEC (1 cycle), o_alu_func per instruction:
  - R-type and immediate ALU ops: next state WB. Immediates set o_src_b_imm=1 and o_reg_dst_rt=1.
  - LW/SW: o_alu_func=ADD, o_src_b_imm=1, next state MEM.
  - BEQ/BNE: o_alu_func=SUB. o_branch = i_alu_zero for BEQ, !i_alu_zero for BNE. o_done=1, next state IDLE.
  - J: o_branch=1, o_done=1, next state IDLE.
- MEM:
  - Hold ADD, o_src_b_imm=1, and o_mem_re (LW) or o_mem_we (SW) until i_mem_ack.
  - On ack: LW goes to WB; SW asserts o_done and goes to IDLE.
  - Arbitrary stall length is allowed.
- WB (1 cycle): o_reg_we=1, o_done=1, hold the EXEC o_alu_func, next state IDLE.
- MDU:
  - Entry cycle: o_mdu_start=1 and counter loads MDU_CYCLES-1.
  - o_mdu_busy=1 throughout; the counter decrements each cycle.
  - When the counter is 0: o_done=1, next state IDLE. No GPR write.
  - MDU_CYCLES=1: start and done occur in the same cycle.
- Latency, measured from the accept cycle T: ALU op retires at T+3; branch at T+2; LW at T+3+stall+1; MDU op at T+1+MDU_CYCLES. o_ready returns the cycle after o_done.
- i_valid while o_ready=0 is ignored (no queueing). i_mem_ack outside MEM is ignored.

Decomposition:
- Package alu_ctrl_pkg holds:
  - opcode and funct localparams;
  - ALU function code localparams;
  - the state encoding (IDLE, DECODE, EXEC, MEM, WB, MDU);
  - the instruction class encoding (ALU, LOAD, STORE, BRANCH, JUMP, MDU, ILLEGAL).
- One combinational sub-module, alu_func_decode: captured {opcode,funct} -> {alu_func, class, src_b_imm, imm_zext, reg_dst_rt, illegal}. It is reusable by the single-cycle core. The FSM and counter stay in alu_ctrl_mc.

Test Plan:
- ADD (op 000000, funct 100000) accepted at cycle 0 -> o_alu_func=1000 in EXEC at cycle 2; o_reg_we=1 and o_done=1 at cycle 3; o_ready=1 at cycle 4.
- ORI (op 001101) -> o_alu_func=1101, o_src_b_imm=1, o_imm_zext=1, o_reg_dst_rt=1; SLT (funct 101010) -> 1010.
- LW (op 100011) with i_mem_ack delayed 3 cycles -> o_mem_re held 4 cycles, then one WB cycle with o_reg_we=1; SW (op 101011) -> o_done on the ack cycle, o_reg_we never asserted.
- BEQ with i_alu_zero=1 -> o_branch=1, o_done=1 at cycle 2; BNE with i_alu_zero=1 -> o_branch=0.
- MULT (funct 011000), MDU_CYCLES=4 -> o_mdu_start pulse at cycle 2, o_mdu_busy for cycles 2-5, o_done at cycle 5; rerun with MDU_CYCLES=1 and ENABLE_MDU=0 -> the latter gives o_illegal at cycle 1.
- Opcode 111111 -> o_illegal=1 at cycle 1, no o_done. i_rst_n low during MEM -> immediate IDLE, o_mem_re=0, o_ready=1. i_valid held during busy cycles -> ignored.
